// File: rtl/uart_tx_fifo.sv
// Serial transmitter with input FIFO: start, LSB-first data, optional parity, stop bits.
// Idle-high line; serial_out and busy are registered one cycle behind the shifter state.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 10000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          idle,
    output logic                          serial_out
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int IW  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   line_q, line_d;
    logic                   busy_q, busy_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   head;
    logic                   push, pop, tick;

    assign in_ready   = (level_q != LW'(FIFO_DEPTH));
    assign fifo_level = level_q;
    assign busy       = busy_q;
    assign idle       = ~busy_q & (level_q == '0);
    assign serial_out = line_q;
    assign push       = in_valid & in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign tick       = (cnt_q == '0);

    // Shifter FSM: bit timing, word pop and line value for the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (PARITY == 1) ? ~^head : ^head;
                    state_d = S_START;
                    cnt_d   = CW'(DIV - 1);
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    cnt_d   = CW'(DIV - 1);
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d   = CW'(DIV - 1);
                    shift_d = shift_q >> 1;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PAR: begin
                if (tick) begin
                    cnt_d   = CW'(DIV - 1);
                    idx_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = CW'(DIV - 1);
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        idx_d = '0;
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = (PARITY == 1) ? ~^head : ^head;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level and busy flag follow the current shifter state
    always_comb begin
        line_d = 1'b1;
        busy_d = (state_q != S_IDLE);
        unique case (state_q)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = shift_q[0];
            S_PAR:   line_d = par_q;
            default: line_d = 1'b1;
        endcase
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2) at DIV=10.
// Stimulus queues expected frames; a negedge monitor checks the line bit by bit.
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    typedef struct {
        logic [15:0] bits;
        int          len;
        bit          contig;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vld [3];
    logic [7:0] din [3];
    logic       rdy [3];
    logic [2:0] lvl [3];
    logic       bsy [3];
    logic       idl [3];
    logic       ser [3];

    exp_t sbq [3][$];
    exp_t cur [3];
    int   mst [3];
    int   mpos [3];
    int   mcyc [3];
    int   mwait [3];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_HZ(1000), .BAUD(100), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u0 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_data(din[0]), .fifo_level(lvl[0]), .busy(bsy[0]),
        .idle(idl[0]), .serial_out(ser[0])
    );

    uart_tx_fifo #(
        .CLK_HZ(1000), .BAUD(100), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u1 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_data(din[1][6:0]), .fifo_level(lvl[1]), .busy(bsy[1]),
        .idle(idl[1]), .serial_out(ser[1])
    );

    uart_tx_fifo #(
        .CLK_HZ(1000), .BAUD(100), .DATA_BITS(7),
        .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u2 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_data(din[2][6:0]), .fifo_level(lvl[2]), .busy(bsy[2]),
        .idle(idl[2]), .serial_out(ser[2])
    );

    function automatic exp_t mk(logic [15:0] b, int n, bit c);
        exp_t e;
        e.bits = b;
        e.len = n;
        e.contig = c;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(int k, logic [7:0] d, exp_t e, output bit ok);
        @(negedge clk);
        vld[k] = 1'b1;
        din[k] = d;
        ok = rdy[k];
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
        if (ok) sbq[k].push_back(e);
    endtask

    // Monitor: pops an expected frame when a start bit appears, checks every cycle
    initial begin
        for (int k = 0; k < 3; k++) begin
            mst[k] = 0; mpos[k] = 0; mcyc[k] = 0; mwait[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (reset) begin
                    mst[k] = 0;
                    mwait[k] = 0;
                    sbq[k].delete();
                end else begin
                    if (mst[k] == 2) begin
                        n_cmp++;
                        if (ser[k] === 1'b0) begin
                            cur[k] = sbq[k].pop_front();
                            mpos[k] = 0; mcyc[k] = 0; mst[k] = 1;
                        end else begin
                            n_fail++;
                            $display("FAIL contig dut%0d: got %0h want 0", k, ser[k]);
                            mst[k] = 0; mwait[k] = 0;
                        end
                    end else if (mst[k] == 0) begin
                        if (sbq[k].size() == 0) begin
                            n_cmp++;
                            if (ser[k] !== 1'b1) begin
                                n_fail++;
                                $display("FAIL idle_line dut%0d: got %0h want 1", k, ser[k]);
                            end
                        end else if (ser[k] === 1'b0) begin
                            cur[k] = sbq[k].pop_front();
                            mpos[k] = 0; mcyc[k] = 0; mst[k] = 1; mwait[k] = 0;
                        end else begin
                            mwait[k]++;
                            if (mwait[k] > 50) begin
                                n_cmp++;
                                n_fail++;
                                $display("FAIL start_timeout dut%0d: got no start want start", k);
                                void'(sbq[k].pop_front());
                                mwait[k] = 0;
                            end
                        end
                    end
                    if (mst[k] == 1) begin
                        n_cmp++;
                        if (ser[k] !== cur[k].bits[mpos[k]]) begin
                            n_fail++;
                            $display("FAIL bit dut%0d pos%0d cyc%0d: got %0h want %0h",
                                     k, mpos[k], mcyc[k], ser[k], cur[k].bits[mpos[k]]);
                        end
                        mcyc[k]++;
                        if (mcyc[k] == DIV) begin
                            mcyc[k] = 0;
                            mpos[k]++;
                            if (mpos[k] == cur[k].len) begin
                                if (sbq[k].size() > 0 && sbq[k][0].contig) mst[k] = 2;
                                else mst[k] = 0;
                                mwait[k] = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    logic [7:0] w [6];
    bit ok;
    int rej;

    initial begin
        w = '{8'h01, 8'h80, 8'h3C, 8'hFF, 8'h00, 8'h5A};
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            din[k] = '0;
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_serial", 32'(ser[k]), 1);
            chk("rst_ready", 32'(rdy[k]), 1);
            chk("rst_idle", 32'(idl[k]), 1);
            chk("rst_level", 32'(lvl[k]), 0);
        end
        reset = 1'b0;

        // 8N1 frame of A5 with latency and duration checks
        push(0, 8'hA5, mk({6'd0, 10'b1_1010_0101_0}, 10, 1'b0), ok);
        chk("a5_accept", 32'(ok), 1);
        @(negedge clk);
        chk("lat_level1", 32'(lvl[0]), 1);
        chk("lat_ser_n", 32'(ser[0]), 1);
        @(negedge clk);
        chk("lat_level0", 32'(lvl[0]), 0);
        chk("lat_ser_n1", 32'(ser[0]), 1);
        chk("lat_busy_n1", 32'(bsy[0]), 0);
        @(negedge clk);
        chk("lat_ser_n2", 32'(ser[0]), 0);
        chk("lat_busy_n2", 32'(bsy[0]), 1);
        repeat (99) @(negedge clk);
        chk("end_busy_last", 32'(bsy[0]), 1);
        @(negedge clk);
        chk("end_busy_off", 32'(bsy[0]), 0);
        chk("end_idle", 32'(idl[0]), 1);
        chk("a5_drained", 32'(sbq[0].size()), 0);

        // 7-bit even and odd parity, two stop bits
        push(1, 8'h13, mk({5'd0, 11'b111_0010011_0}, 11, 1'b0), ok);
        chk("e13_accept", 32'(ok), 1);
        push(2, 8'h13, mk({5'd0, 11'b110_0010011_0}, 11, 1'b0), ok);
        chk("o13_accept", 32'(ok), 1);
        repeat (130) @(negedge clk);
        chk("even_idle", 32'(idl[1]), 1);
        chk("odd_idle", 32'(idl[2]), 1);
        chk("even_drained", 32'(sbq[1].size()), 0);
        chk("odd_drained", 32'(sbq[2].size()), 0);

        // back-pressure: six words into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            push(0, w[i], mk({6'd0, 1'b1, w[i], 1'b0}, 10, i > 0), ok);
            chk("bp_accept", 32'(ok), 1);
        end
        @(negedge clk);
        chk("bp_level_full", 32'(lvl[0]), 4);
        chk("bp_ready_low", 32'(rdy[0]), 0);
        vld[0] = 1'b1;
        din[0] = w[5];
        rej = 0;
        while (rdy[0] !== 1'b1 && rej < 300) begin
            rej++;
            @(negedge clk);
        end
        chk("bp_rejected_edges", 32'(rej), 97);
        chk("simul_level", 32'(lvl[0]), 3);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        sbq[0].push_back(mk({6'd0, 1'b1, w[5], 1'b0}, 10, 1'b1));
        @(negedge clk);
        chk("bp_level_after", 32'(lvl[0]), 4);
        repeat (520) @(negedge clk);
        chk("bp_idle", 32'(idl[0]), 1);
        chk("bp_drained", 32'(sbq[0].size()), 0);

        // reset during data bit 3 with a second word queued
        push(0, 8'hC3, mk({6'd0, 1'b1, 8'hC3, 1'b0}, 10, 1'b0), ok);
        push(0, 8'h11, mk({6'd0, 1'b1, 8'h11, 1'b0}, 10, 1'b1), ok);
        repeat (44) @(negedge clk);
        chk("pre_rst_busy", 32'(bsy[0]), 1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_serial", 32'(ser[0]), 1);
        chk("mid_rst_level", 32'(lvl[0]), 0);
        chk("mid_rst_busy", 32'(bsy[0]), 0);
        chk("mid_rst_ready", 32'(rdy[0]), 1);
        #1;
        reset = 1'b0;
        repeat (300) @(negedge clk);
        chk("post_rst_idle", 32'(idl[0]), 1);
        chk("post_rst_serial", 32'(ser[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
